// File: rtl/pmod_gpio_if.sv
// Local-bus register port of the PMOD GPIO block.
// Latency: lb_rdata is registered, 1 cycle after lb_addr; irq is combinational from EVENT.
// Backpressure: none; every write strobe is accepted on the edge it is sampled.
//
// Signals:
//   lb_write  - register write strobe
//   lb_addr   - register select (0 OUT, 1 OE, 2 IN, 3 EVENT)
//   lb_wdata  - write data, one bit per pin
//   lb_rdata  - registered read data
//   irq       - OR of all EVENT bits
interface pmod_gpio_if #(
    parameter int NPIN = 8
);
    logic            lb_write;
    logic [1:0]      lb_addr;
    logic [NPIN-1:0] lb_wdata;
    logic [NPIN-1:0] lb_rdata;
    logic            irq;

    modport master (
        output lb_write,
        output lb_addr,
        output lb_wdata,
        input  lb_rdata,
        input  irq
    );

    modport slave (
        input  lb_write,
        input  lb_addr,
        input  lb_wdata,
        output lb_rdata,
        output irq
    );
endinterface

// File: rtl/pmod_gpio.sv
// NPIN-wide PMOD GPIO: per-pin OUT/OE registers, 2-flop input sync, sticky edge events + irq.
// Latency: pin->IN 2 edges, pin->EVENT 3 edges (+2^FILT_W-1 with the glitch filter); reads 1 cycle.
// Backpressure: none; writes always land, reads have no side effects.
//
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset (tri-states every pin at once)
//   pin       - PMOD connector pins, driven with OUT where OE=1, otherwise hi-Z
//   bus       - pmod_gpio_if.slave local-bus register port plus irq
//
// Build option: define PMOD_GLITCH_FILTER_EN to put a FILT_W-bit run-length filter
// behind each synchroniser. Without it FILT_W is unused and level is the sync2 output.
module pmod_gpio #(
    parameter int NPIN   = 8,
    parameter int FILT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire  [NPIN-1:0] pin,
    pmod_gpio_if.slave      bus
);

    logic [NPIN-1:0] out_q;
    logic [NPIN-1:0] oe_q;
    logic [NPIN-1:0] sync1;
    logic [NPIN-1:0] sync2;
    logic [NPIN-1:0] level;
    logic [NPIN-1:0] level_d;
    logic [NPIN-1:0] event_q;
    logic [NPIN-1:0] event_clr;
    logic [NPIN-1:0] rd_mux;

    // Pin drivers; OE is cleared asynchronously so reset releases the pins at once.
    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        assign pin[i] = oe_q[i] ? out_q[i] : 1'bz;
    end

    // Input synchronisers sample the pad even when the pin is driven, so outputs read back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef PMOD_GLITCH_FILTER_EN
    // filt follows sync2 only after it has differed on 2^FILT_W-1 consecutive edges.
    // The counter holds the number of differing edges already seen, so the update
    // happens on the edge where that count would reach the maximum.
    localparam logic [FILT_W-1:0] CNT_LAST = {{(FILT_W-1){1'b1}}, 1'b0};
    localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};

    logic [NPIN-1:0]   filt;
    logic [FILT_W-1:0] filt_cnt [NPIN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < NPIN; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPIN; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CNT_LAST) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Write-1-to-clear mask for EVENT; zero unless this edge carries an EVENT write.
    assign event_clr = (bus.lb_write && (bus.lb_addr == 2'd3)) ? bus.lb_wdata : '0;

    always_comb begin
        rd_mux = '0;
        unique case (bus.lb_addr)
            2'd0: rd_mux = out_q;
            2'd1: rd_mux = oe_q;
            2'd2: rd_mux = level;
            2'd3: rd_mux = event_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            oe_q         <= '0;
            level_d      <= '0;
            event_q      <= '0;
            bus.lb_rdata <= '0;
        end else begin
            if (bus.lb_write && (bus.lb_addr == 2'd0)) begin
                out_q <= bus.lb_wdata;
            end
            if (bus.lb_write && (bus.lb_addr == 2'd1)) begin
                oe_q <= bus.lb_wdata;
            end
            level_d <= level;
            // Set is ORed in after the clear so a fresh edge is never lost to a clear.
            event_q      <= (event_q & ~event_clr) | (level ^ level_d);
            bus.lb_rdata <= rd_mux;
        end
    end

    assign bus.irq = |event_q;

endmodule
